dg0045_ram_arbiter: RTL and testbench

Shared-access controller for the DG0045 64×4 data RAM. It owns the RAM array and arbitrates it between the CPU core and a host debug/load port using a fixed time-slot scheme locked to the core's 8-clock machine cycle. The core keeps exclusive use of the RAM during its sampling and write phases. The host gets one RAM slot per machine cycle through a four-phase req/ack handshake.

---
 rtl/dg0045_ram_arbiter.sv | 101 ++++++++++
 tb/tb_dg0045_ram_arbiter.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/dg0045_ram_arbiter.sv
// dg0045_ram_arbiter: 64x4 data RAM shared between the core and a host port via a phase-locked slot.
// Optional DG0045_HOST_AUTOINC_EN adds a host auto-increment address pointer.
module dg0045_ram_arbiter #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic              RESET,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_din,
    input  logic              core_we,
    output logic [DATA_W-1:0] core_dout,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    input  logic              host_inc,
    output logic              host_ack,
    output logic [DATA_W-1:0] host_rdata,
    output logic [2:0]        phase
);
    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_ACCESS, S_ACK, S_DONE} state_t;
    state_t            state_q, state_d;
    logic [2:0]        phase_q, phase_d;
    logic [ADDR_W-1:0] haddr_q, haddr_d, req_addr, ram_addr;
    logic              hwe_q, hwe_d;
    logic [DATA_W-1:0] hwdata_q, hwdata_d, rdata_q, rdata_d;
    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic              latch, host_wr, core_wr;

`ifdef DG0045_HOST_AUTOINC_EN
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    always_comb begin
        req_addr = host_inc ? ptr_q : host_addr;
        ptr_d    = (state_q == S_ACCESS) ? haddr_q + ADDR_W'(1) : ptr_q;
    end
    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end
`else
    logic unused_inc;
    assign unused_inc = host_inc;
    assign req_addr   = host_addr;
`endif

    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            state_q  <= S_IDLE;
            phase_q  <= '0;
            haddr_q  <= '0;
            hwe_q    <= 1'b0;
            hwdata_q <= '0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            haddr_q  <= haddr_d;
            hwe_q    <= hwe_d;
            hwdata_q <= hwdata_d;
            rdata_q  <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (host_req) state_d = (phase_q == 3'd7) ? S_ACCESS : S_WAIT;
            S_WAIT:   if (phase_q == 3'd7) state_d = S_ACCESS;
            S_ACCESS: state_d = S_ACK;
            S_ACK:    state_d = S_DONE;
            S_DONE:   if (!host_req) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Host and core write slots are disjoint (phase 0 vs phase 6), so no priority is needed
    always_comb begin
        phase_d  = phase_q + 3'd1;
        latch    = (state_q == S_IDLE) && host_req;
        haddr_d  = latch ? req_addr : haddr_q;
        hwe_d    = latch ? host_we : hwe_q;
        hwdata_d = latch ? host_wdata : hwdata_q;
        rdata_d  = (state_q == S_ACCESS) ? mem[haddr_q] : rdata_q;
        host_wr  = (state_q == S_ACCESS) && hwe_q;
        core_wr  = (phase_q == 3'd6) && core_we;
        ram_addr = (state_q == S_ACCESS) ? haddr_q : core_addr;
    end

    always_ff @(posedge clk) begin
        if (host_wr)      mem[haddr_q]   <= hwdata_q;
        else if (core_wr) mem[core_addr] <= core_din;
    end

    always_comb begin
        host_ack   = (state_q == S_ACK);
        host_rdata = rdata_q;
        phase      = phase_q;
        core_dout  = mem[ram_addr];
    end
endmodule

// File: tb/tb_dg0045_ram_arbiter.sv
// tb_dg0045_ram_arbiter: directed plus randomized checks of the RAM arbiter against a slot-level model.
// Build with DG0045_HOST_AUTOINC_EN to also cover the auto-increment pointer.
module tb_dg0045_ram_arbiter;
    logic       clk = 1'b0;
    logic       RESET = 1'b0;
    logic [5:0] core_addr = '0;
    logic [3:0] core_din = '0;
    logic       core_we = 1'b0;
    logic [3:0] core_dout;
    logic       host_req = 1'b0;
    logic       host_we = 1'b0;
    logic [5:0] host_addr = '0;
    logic [3:0] host_wdata = '0;
    logic       host_inc = 1'b0;
    logic       host_ack;
    logic [3:0] host_rdata;
    logic [2:0] phase;

    int         checks = 0;
    int         failures = 0;
    int         ph = 0;
    logic [3:0] ref_mem [64];
    logic [5:0] ref_ptr = '0;
    bit         rand_core = 0;

    always #5 clk = ~clk;

    dg0045_ram_arbiter dut (
        .clk(clk), .RESET(RESET),
        .core_addr(core_addr), .core_din(core_din), .core_we(core_we), .core_dout(core_dout),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_inc(host_inc), .host_ack(host_ack), .host_rdata(host_rdata), .phase(phase)
    );

    // Locations never written are unknown in the model and are not compared
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        if (!$isunknown(exp)) begin
            checks++;
            assert (obs === exp) else begin
                failures++;
                $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
            end
        end
    endtask

    task automatic step();
        if (rand_core) begin
            core_we   = 1'($urandom);
            core_addr = 6'($urandom);
            core_din  = 4'($urandom);
        end
        if (ph == 6 && core_we) ref_mem[core_addr] = core_din;
        @(posedge clk);
        #1;
        ph = (ph + 1) % 8;
        chk("phase", 32'(phase), 32'(ph));
        if (ph >= 2) chk("core_dout", 32'(core_dout), 32'(ref_mem[core_addr]));
    endtask

    task automatic xfer(input bit we, input logic [5:0] addr, input logic [3:0] wd, input bit inc,
                        output logic [3:0] rd, output int lat);
        int         exp_lat;
        bit         seen;
        logic [5:0] eff;
        eff = addr;
`ifdef DG0045_HOST_AUTOINC_EN
        if (inc) eff = ref_ptr;
`endif
        host_we = we; host_addr = addr; host_wdata = wd; host_inc = inc; host_req = 1'b1;
        exp_lat = (7 - ph) + 2;
        lat = 0;
        seen = 0;
        while (!seen && lat < 12) begin
            step();
            lat++;
            seen = host_ack;
        end
        chk("ack_seen", 32'(seen), 32'd1);
        chk("latency", 32'(lat), 32'(exp_lat));
        chk("ack_phase", 32'(phase), 32'd1);
        chk("host_rdata", 32'(host_rdata), 32'(ref_mem[eff]));
        rd = host_rdata;
        if (we) ref_mem[eff] = wd;
        ref_ptr = eff + 6'd1;
        host_req = 1'b0;
        step();
        chk("ack_one_cycle", 32'(host_ack), 32'd0);
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] rd;
        int         lat;
        int         acks;
        for (int i = 0; i < 64; i++) ref_mem[i] = 'x;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_phase", 32'(phase), 32'd0);
        chk("reset_ack", 32'(host_ack), 32'd0);
        chk("reset_rdata", 32'(host_rdata), 32'd0);
        RESET = 1'b1;
        ph = 0;

        xfer(1, 6'h2A, 4'h9, 0, rd, lat);
        xfer(0, 6'h2A, 4'h0, 0, rd, lat);
        chk("readback_2a", 32'(rd), 32'h9);

        for (int i = 0; i < 8 && ph != 7; i++) step();
        xfer(0, 6'h2A, 4'h0, 0, rd, lat);
        chk("lat_min", 32'(lat), 32'd2);
        for (int i = 0; i < 8 && ph != 0; i++) step();
        xfer(0, 6'h2A, 4'h0, 0, rd, lat);
        chk("lat_max", 32'(lat), 32'd9);

        core_we = 1'b1; core_addr = 6'h05; core_din = 4'h3;
        xfer(1, 6'h06, 4'hC, 0, rd, lat);
        repeat (10) step();
        core_we = 1'b0;
        xfer(0, 6'h06, 4'h0, 0, rd, lat);
        chk("interleave_06", 32'(rd), 32'hC);
        xfer(0, 6'h05, 4'h0, 0, rd, lat);
        chk("interleave_05", 32'(rd), 32'h3);

        acks = 0;
        host_we = 1'b0; host_addr = 6'h06; host_inc = 1'b0; host_req = 1'b1;
        repeat (40) begin
            step();
            if (host_ack) acks++;
        end
        chk("held_acks", 32'(acks), 32'd1);
        host_req = 1'b0;
        step();
        step();
        xfer(0, 6'h06, 4'h0, 0, rd, lat);
        chk("after_held", 32'(rd), 32'hC);

        xfer(1, 6'h10, 4'h1, 0, rd, lat);
        host_we = 1'b1; host_addr = 6'h10; host_wdata = 4'hF; host_req = 1'b1;
        for (int i = 0; i < 9 && ph != 0; i++) step();
        RESET = 1'b0;
        #2;
        chk("async_rst_phase", 32'(phase), 32'd0);
        host_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        RESET = 1'b1;
        ph = 0;
        chk("rst_phase", 32'(phase), 32'd0);
        chk("rst_ack", 32'(host_ack), 32'd0);
        chk("rst_rdata", 32'(host_rdata), 32'd0);
        ref_ptr = '0;
        xfer(0, 6'h10, 4'h0, 0, rd, lat);
        chk("rst_dropped_write", 32'(rd), 32'h1);

`ifdef DG0045_HOST_AUTOINC_EN
        xfer(1, 6'h3F, 4'h7, 0, rd, lat);
        xfer(1, 6'h22, 4'hA, 1, rd, lat);
        xfer(1, 6'h33, 4'hB, 1, rd, lat);
        xfer(0, 6'h00, 4'h0, 0, rd, lat);
        chk("autoinc_00", 32'(rd), 32'hA);
        xfer(0, 6'h01, 4'h0, 0, rd, lat);
        chk("autoinc_01", 32'(rd), 32'hB);
`endif

        rand_core = 1;
        repeat (30) begin
            repeat ($urandom_range(0, 7)) step();
            xfer(1'($urandom), 6'($urandom), 4'($urandom), 1'($urandom), rd, lat);
        end
        rand_core = 0;
        core_we = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
